// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, motor PWM frame length and measurement states
package pwm_pkg;
    localparam int DUTY_W_DEF = 11;
    localparam int PER_W_DEF = 12;
    localparam int PWM_PERIOD = 2048;
    typedef enum logic {IDLE, MEAS} state_t;
endpackage

// File: rtl/pwm_sync.sv
// pwm_sync: two-flop synchronizer bringing the asynchronous PWM line into clk
module pwm_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, m} <= 2'b00;
        else {q, m} <= {m, d};
endmodule

// File: rtl/pwm_meas.sv
// pwm_meas: measures high time and period of a PWM line, reports a stuck line on timeout
module pwm_meas import pwm_pkg::*; #(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int PER_W = PER_W_DEF,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PWM_in,
    output logic [DUTY_W-1:0] duty,
    output logic [PER_W-1:0]  period,
    output logic              vld,
    output logic              stuck
);
    state_t state;
    logic s, prev, rise, tmo;
    logic [1:0] flush;
    logic [PER_W-1:0] per_cnt, lim;
    logic [DUTY_W-1:0] hi_cnt;
    pwm_sync u_sync (.clk(clk), .rst_n(rst_n), .d(PWM_in), .q(s));
    // IDLE counts from 0 and MEAS from 1, so both time out TIMEOUT cycles after their start
    always_comb begin
        lim = state == IDLE ? PER_W'(TIMEOUT - 1) : PER_W'(TIMEOUT);
        rise = s & ~prev;
        tmo = ~rise & (per_cnt == lim);
    end
    // prev is held high until the synchronizer has flushed its reset zeros,
    // so a line already high at reset release is not mistaken for a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            flush <= 2'b00;
            prev <= 1'b1;
            per_cnt <= '0;
            hi_cnt <= '0;
            duty <= '0;
            period <= '0;
            vld <= 1'b0;
            stuck <= 1'b0;
        end else begin
            flush <= {flush[0], 1'b1};
            prev <= s | ~flush[1];
            vld <= 1'b0;
            if (rise) begin
                state <= MEAS;
                per_cnt <= PER_W'(1);
                hi_cnt <= DUTY_W'(1);
                if (state == MEAS) begin
                    duty <= hi_cnt;
                    period <= per_cnt;
                    stuck <= 1'b0;
                    vld <= 1'b1;
                end
            end else if (tmo) begin
                state <= IDLE;
                per_cnt <= '0;
                hi_cnt <= '0;
                duty <= {DUTY_W{s}};
                period <= '0;
                stuck <= 1'b1;
                vld <= 1'b1;
            end else begin
                per_cnt <= per_cnt + 1'b1;
                if (state == MEAS && s && hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas: directed PWM waveforms with a scoreboard of expected reports and their arrival cycles
module tb_pwm_meas;
    import pwm_pkg::*;
    localparam int TMO = 4095;
    localparam int DMAX = 2047;

    typedef struct {
        int duty;
        int period;
        bit stuck;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_in = 1'b0;
    logic [DUTY_W_DEF-1:0] duty;
    logic [PER_W_DEF-1:0] period;
    logic vld, stuck;

    exp_t q[$];
    exp_t e;
    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    int prev_hi = -1;
    int prev_per = 0;
    bit done = 1'b0;

    pwm_meas dut (
        .clk(clk), .rst_n(rst_n), .PWM_in(pwm_in),
        .duty(duty), .period(period), .vld(vld), .stuck(stuck)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;

    // One period: high for hi cycles then low for lo cycles, starting at a negedge.
    // The report of the previous period appears 3 edges after this rise is driven;
    // a period longer than TMO yields stuck reports instead, every TMO cycles.
    task automatic pwm(input int hi, input int lo);
        int n = cyc;
        if (prev_hi >= 0) q.push_back('{prev_hi, prev_per, 1'b0, n + 3});
        for (int t = n + TMO + 3; t <= n + hi + lo + 2; t += TMO)
            q.push_back('{(t <= n + hi + 2) ? DMAX : 0, 0, 1'b1, t});
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
        prev_hi = (hi + lo > TMO) ? -1 : ((hi > DMAX) ? DMAX : hi);
        prev_per = hi + lo;
    endtask

    always @(negedge clk) begin
        if (done) begin
            ncmp++;
            if (q.size() != 0) begin
                nfail++;
                $display("FAIL leftover: %0d reports still pending, required 0", q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
            $finish;
        end else if (!rst_n) begin
            ncmp++;
            if (duty !== '0 || period !== '0 || vld !== 1'b0 || stuck !== 1'b0) begin
                nfail++;
                $display("FAIL reset_outputs: duty=%0d period=%0d vld=%0b stuck=%0b, required all 0",
                         duty, period, vld, stuck);
            end
        end else if (vld) begin
            ncmp++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_vld: duty=%0d period=%0d stuck=%0b cyc=%0d, required no report",
                         duty, period, stuck, cyc);
            end else begin
                e = q.pop_front();
                if (int'(duty) != e.duty || int'(period) != e.period || stuck !== e.stuck || cyc != e.cyc) begin
                    nfail++;
                    $display("FAIL report: duty=%0d period=%0d stuck=%0b cyc=%0d, required duty=%0d period=%0d stuck=%0b cyc=%0d",
                             duty, period, stuck, cyc, e.duty, e.period, e.stuck, e.cyc);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        // line held low: stuck reports at 4095 and 8190 cycles after release
        q.push_back('{0, 0, 1'b1, 4095});
        q.push_back('{0, 0, 1'b1, 8190});
        repeat (8200) @(negedge clk);
        // duty 512 steady, then a step to 1536 at a period boundary
        repeat (4) pwm(512, PWM_PERIOD - 512);
        repeat (3) pwm(1536, PWM_PERIOD - 1536);
        // period exactly TIMEOUT is a normal report; one cycle longer times out
        pwm(10, TMO - 10);
        pwm(10, TMO - 9);
        // line stuck high, then a 100/300 square wave
        pwm(8300, 300);
        repeat (3) pwm(100, 300);
        // reset in the middle of a 1000-cycle high phase
        repeat (2) pwm(1000, PWM_PERIOD - 1000);
        q.push_back('{1000, PWM_PERIOD, 1'b0, cyc + 3});
        pwm_in = 1'b1;
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        prev_hi = -1;
        repeat (800) @(negedge clk);
        pwm_in = 1'b0;
        repeat (PWM_PERIOD - 1000) @(negedge clk);
        repeat (2) pwm(1000, PWM_PERIOD - 1000);
        // one-cycle glitch, saturated high time, short closing periods
        pwm(1, 20);
        pwm(3000, 500);
        repeat (2) pwm(5, 5);
        repeat (20) @(negedge clk);
        done = 1'b1;
    end
endmodule
